uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Bridges the UART receiver and the CPU core. While Load is high it takes each received
//  byte (Rx_data/Rx_valid/Rx_fe) and writes it to consecutive instruction-memory
//  addresses from 0.
//  It holds the core stopped (Cpu_run=0) until loading ends, then releases it.
//  Frame errors and overflow are reported via a sticky Load_err.
// PARAMETERS
//  ADDR_W   4   instruction-memory address width; DEPTH = 2**ADDR_W bytes (16)
//  DATA_W   8   byte width; fixed at 8, Rx_data and Imem_wdata use it
// PORTS
//  Clk         in   1       system clock; all logic on rising edge
//  Reset       in   1       synchronous, active-low reset (0 = reset, sampled on Clk rise)
//  Load        in   1       level; 1 = program-load window open
//  Rx_data     in   8       byte from UART receiver, valid only with Rx_valid
//  Rx_valid    in   1       1-cycle pulse per received byte (after stop bit)
//  Rx_fe       in   1       frame error for the byte qualified by Rx_valid
//  Imem_we     out  1       instruction-memory write strobe, 1 cycle per write
//  Imem_addr   out  ADDR_W  write address
//  Imem_wdata  out  8       write data
//  Byte_count  out  ADDR_W+1  number of good bytes written this load (0..DEPTH)
//  Load_err    out  1       sticky: frame error or overflow seen during current load
//  Cpu_run     out  1       1 = core may execute; 0 = core held
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset=0 forces state IDLE: Imem_we=0, Imem_addr=0, Imem_wdata=0, Byte_count=0,
//    Load_err=0, Cpu_run=0. Applies in any state, including mid-load or mid-fill.
//  - States:
//    - IDLE: Cpu_run=0.
//      - Load=1 -> LOAD; clear Byte_count and Load_err; write pointer = 0.
//    - LOAD: Cpu_run=0.
//      - Rx_valid=1 & Rx_fe=0 & Byte_count<DEPTH: next cycle Imem_we=1,
//        Imem_addr=pointer, Imem_wdata=Rx_data; pointer++, Byte_count++.
//        Latency from Rx_valid to Imem_we is exactly 1 cycle.
//      - Rx_valid=1 & Rx_fe=1: byte dropped, no write, Load_err<=1.
//      - Rx_valid=1 & Byte_count==DEPTH: overflow; byte dropped, Load_err<=1.
//        The pointer does not wrap.
//      - Load=0 -> COMMIT. A byte whose Rx_valid coincides with the Load=0 cycle is
//        still accepted under the rules above.
//    - COMMIT: one cycle, no write.
//      - Macro set: -> FILL if Byte_count<DEPTH, else -> RUN.
//      - Macro not set: -> RUN.
//    - FILL (macro set only): one write per cycle of 0x00 to
//      addresses Byte_count..DEPTH-1 (Imem_we=1 each cycle); then -> RUN.
//      Byte_count is not changed by the fill.
//    - RUN: Cpu_run=1 and Imem_we=0.
//      - Rx_valid is ignored.
//      - Load=1 -> LOAD; Cpu_run falls the next cycle; counters and Load_err cleared.
//  - Imem_we is 0 in every state except the write cycles listed above.
//  - Load_err stays set through RUN until the next LOAD entry or reset.
//  - Load pulses are never missed: Load is level-sampled every cycle in IDLE and RUN.
// CONFIGURATION
//  LOADER_ZERO_FILL_EN
//  - Defined: after a load, unused instruction-memory locations are cleared to 0x00
//    through the FILL state before Cpu_run rises. Release latency =
//    2 + (DEPTH - Byte_count) cycles after Load falls.
//  - Undefined: there is no FILL state, and Cpu_run rises 2 cycles after Load falls
//    (through COMMIT); unused memory locations keep their previous contents.
// TESTING
//  1. Reset=0 for 3 cycles, then 1 -> all outputs 0, state IDLE, Cpu_run=0.
//  2. Load=1, send bytes 55,A3,FF,00 (Rx_fe=0), Load=0 -> writes at addr 0..3 with
//     data 55,A3,FF,00, each 1 cycle after its Rx_valid; Byte_count=4, Load_err=0.
//     Cpu_run=1 2 cycles after Load falls; with the macro set, 2+12 cycles after.
//  3. Load=1, bytes 11 and 22 (with Rx_fe=1), then 33 -> addr0=11, addr1=33;
//     Byte_count=2, Load_err=1, still 1 in RUN.
//  4. Load=1, 17 good bytes -> 16 writes (addr 0..15), 17th byte dropped;
//     Byte_count=16, Load_err=1; with the macro set, no FILL cycles.
//  5. In RUN, pulse Rx_valid (data 7E) -> no write. Then Load=1 -> Cpu_run=0 next cycle,
//     Byte_count=0, Load_err=0.
//  6. Reset=0 mid-LOAD after 2 writes, and separately mid-FILL -> next cycle IDLE,
//     Imem_we=0, Byte_count=0, Cpu_run=0.

Source files
------------

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//
// Bridges a UART byte receiver and a small CPU core. While Load is high, every good
// received byte is written to consecutive instruction-memory addresses starting at 0.
// The core is held (Cpu_run=0) until the load window closes. It is then released
// through a one-cycle COMMIT state.
//
// Frame errors and overflow (more than DEPTH bytes) drop the byte. They also set a sticky
// Load_err. Load_err stays set until the next load starts or reset is applied.
//
// Optional feature (macro LOADER_ZERO_FILL_EN):
//   When defined, a FILL state clears the unused memory locations Byte_count..DEPTH-1
//   to 0x00 before the core is released. Release latency is then 2 + (DEPTH - Byte_count)
//   cycles after Load falls.
//   When undefined, the core is released 2 cycles after Load falls. Unused locations
//   keep their previous contents.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-low reset
//   Load       in   level, 1 = program-load window open
//   Rx_data    in   received byte, qualified by Rx_valid
//   Rx_valid   in   one-cycle pulse per received byte
//   Rx_fe      in   frame error for the byte qualified by Rx_valid
//   Imem_we    out  instruction-memory write strobe (registered)
//   Imem_addr  out  write address (registered)
//   Imem_wdata out  write data (registered)
//   Byte_count out  good bytes written during the current load, 0..DEPTH
//   Load_err   out  sticky frame-error / overflow flag for the current load
//   Cpu_run    out  1 = core may execute
module uart_imem_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] Rx_data,
  input  logic              Rx_valid,
  input  logic              Rx_fe,
  output logic              Imem_we,
  output logic [ADDR_W-1:0] Imem_addr,
  output logic [DATA_W-1:0] Imem_wdata,
  output logic [ADDR_W:0]   Byte_count,
  output logic              Load_err,
  output logic              Cpu_run
);

  localparam int unsigned   Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

`ifdef LOADER_ZERO_FILL_EN
  typedef enum logic [2:0] {StIdle, StLoad, StCommit, StFill, StRun} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StCommit, StRun} state_e;
`endif

  state_e              state_q, state_d;
  // Write pointer is one bit wider than the address so it can reach DEPTH without wrapping.
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                run_q, run_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (Load) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      StLoad: begin
        // A byte arriving in the same cycle Load drops is still handled here.
        if (Rx_valid) begin
          if (Rx_fe) begin
            err_d = 1'b1;
          end else if (count_q == DepthCnt) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q[ADDR_W-1:0];
            wdata_d = Rx_data;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        if (!Load) begin
          state_d = StCommit;
        end
      end

      StCommit: begin
`ifdef LOADER_ZERO_FILL_EN
        // Issue the first fill write on the edge that enters FILL, so every FILL cycle
        // presents exactly one write and RUN never sees a write strobe.
        if (ptr_q < DepthCnt) begin
          state_d = StFill;
          we_d    = 1'b1;
          addr_d  = ptr_q[ADDR_W-1:0];
          wdata_d = '0;
          ptr_d   = ptr_q + 1'b1;
        end else begin
          state_d = StRun;
        end
`else
        state_d = StRun;
`endif
      end

`ifdef LOADER_ZERO_FILL_EN
      StFill: begin
        if (ptr_q == DepthCnt) begin
          state_d = StRun;
        end else begin
          we_d    = 1'b1;
          addr_d  = ptr_q[ADDR_W-1:0];
          wdata_d = '0;
          ptr_d   = ptr_q + 1'b1;
        end
      end
`endif

      StRun: begin
        // Received bytes are ignored while the core runs.
        if (Load) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Cpu_run is registered from the next state so it rises on the RUN entry edge.
    run_d = (state_d == StRun);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
    end
  end

  assign Imem_we    = we_q;
  assign Imem_addr  = addr_q;
  assign Imem_wdata = wdata_q;
  assign Byte_count = count_q;
  assign Load_err   = err_q;
  assign Cpu_run    = run_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader. Stimulus pushes expected memory writes (cycle, address,
// data) into a queue. A negedge monitor pops and compares each write the DUT presents.
// Status outputs are checked directly against hand-computed values.
module tb_uart_imem_loader;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Load;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Rx_fe;
  logic       Imem_we;
  logic [3:0] Imem_addr;
  logic [7:0] Imem_wdata;
  logic [4:0] Byte_count;
  logic       Load_err;
  logic       Cpu_run;

  uart_imem_loader #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Rx_data   (Rx_data),
    .Rx_valid  (Rx_valid),
    .Rx_fe     (Rx_fe),
    .Imem_we   (Imem_we),
    .Imem_addr (Imem_addr),
    .Imem_wdata(Imem_wdata),
    .Byte_count(Byte_count),
    .Load_err  (Load_err),
    .Cpu_run   (Cpu_run)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Scoreboard monitor: every write must match the head of the queue in cycle, addr, data.
  always @(negedge Clk) begin
    wr_t e;
    if (Imem_we === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cyc %0d addr %h data %h, required no write",
                 cyc, Imem_addr, Imem_wdata);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.a !== Imem_addr || e.d !== Imem_wdata) begin
          n_fail++;
          $display("FAIL write: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                   cyc, Imem_addr, Imem_wdata, e.c, e.a, e.d);
        end
      end
    end else if (q.size() > 0 && q[0].c < cyc) begin
      n_tests++;
      n_fail++;
      e = q.pop_front();
      $display("FAIL missed_write: no write by cyc %0d, required addr %h data %h at cyc %0d",
               cyc, e.a, e.d, e.c);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One received byte followed by an idle gap cycle.
  task automatic send(input logic [7:0] d, input logic fe, input bit wr, input logic [3:0] a);
    Rx_data  = d;
    Rx_fe    = fe;
    Rx_valid = 1'b1;
    if (wr) q.push_back('{cyc + 1, a, d});
    step();
    Rx_valid = 1'b0;
    Rx_fe    = 1'b0;
    step();
  endtask

  task automatic start_load();
    Load = 1'b1;
    step();
    check("load_entry_cpu_run", int'(Cpu_run), 0);
    check("load_entry_count", int'(Byte_count), 0);
    check("load_entry_err", int'(Load_err), 0);
  endtask

  // Drop Load (optionally with a coincident byte) and measure release latency.
  task automatic end_load(input int cnt, input bit with_byte, input logic [7:0] d,
                          input logic [3:0] a);
    int c0;
    int lat;
    int exp_lat;
    Load = 1'b0;
    c0   = cyc;
    if (with_byte) begin
      Rx_data  = d;
      Rx_fe    = 1'b0;
      Rx_valid = 1'b1;
      q.push_back('{c0 + 1, a, d});
    end
    exp_lat = 2;
`ifdef LOADER_ZERO_FILL_EN
    for (int i = cnt; i < 16; i++) q.push_back('{c0 + 2 + (i - cnt), 4'(i), 8'h00});
    exp_lat = 2 + 16 - cnt;
`endif
    lat = 0;
    do begin
      step();
      Rx_valid = 1'b0;
      lat++;
    end while (Cpu_run !== 1'b1 && lat < 40);
    check("release_latency", lat, exp_lat);
    check("count_after_load", int'(Byte_count), cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b0;
    Load     = 1'b0;
    Rx_data  = 8'h00;
    Rx_valid = 1'b0;
    Rx_fe    = 1'b0;

    // 1. Reset for 3 cycles.
    repeat (3) step();
    Reset = 1'b1;
    step();
    check("rst_we", int'(Imem_we), 0);
    check("rst_addr", int'(Imem_addr), 0);
    check("rst_wdata", int'(Imem_wdata), 0);
    check("rst_count", int'(Byte_count), 0);
    check("rst_err", int'(Load_err), 0);
    check("rst_cpu_run", int'(Cpu_run), 0);

    // 2. Four good bytes; the last one coincides with Load falling.
    start_load();
    send(8'h55, 1'b0, 1'b1, 4'd0);
    send(8'hA3, 1'b0, 1'b1, 4'd1);
    send(8'hFF, 1'b0, 1'b1, 4'd2);
    end_load(4, 1'b1, 8'h00, 4'd3);
    check("t2_err", int'(Load_err), 0);

    // 3. Frame error drops a byte and sets the sticky error.
    start_load();
    send(8'h11, 1'b0, 1'b1, 4'd0);
    send(8'h22, 1'b1, 1'b0, 4'd0);
    send(8'h33, 1'b0, 1'b1, 4'd1);
    end_load(2, 1'b0, 8'h00, 4'd0);
    check("t3_err_in_run", int'(Load_err), 1);
    step();
    check("t3_err_sticky", int'(Load_err), 1);

    // 4. Seventeen good bytes: the 17th overflows.
    start_load();
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0, 1'b1, 4'(i));
    send(8'hAA, 1'b0, 1'b0, 4'd0);
    end_load(16, 1'b0, 8'h00, 4'd0);
    check("t4_err", int'(Load_err), 1);

    // 5. Bytes in RUN are ignored; a new load clears status.
    send(8'h7E, 1'b0, 1'b0, 4'd0);
    check("t5_still_run", int'(Cpu_run), 1);
    start_load();

    // 6a. Reset mid-load after two writes.
    send(8'h01, 1'b0, 1'b1, 4'd0);
    send(8'h02, 1'b0, 1'b1, 4'd1);
    check("t6_count_before", int'(Byte_count), 2);
    Reset = 1'b0;
    Load  = 1'b0;
    step();
    check("t6_we", int'(Imem_we), 0);
    check("t6_count", int'(Byte_count), 0);
    check("t6_cpu_run", int'(Cpu_run), 0);
    check("t6_err", int'(Load_err), 0);
    Reset = 1'b1;
    step();
    check("t6_idle_cpu_run", int'(Cpu_run), 0);

`ifdef LOADER_ZERO_FILL_EN
    // 6b. Reset in the middle of FILL.
    begin
      int c0;
      start_load();
      send(8'h5A, 1'b0, 1'b1, 4'd0);
      c0   = cyc;
      Load = 1'b0;
      step();
      q.push_back('{c0 + 2, 4'd1, 8'h00});
      step();
      Reset = 1'b0;
      step();
      check("t6b_we", int'(Imem_we), 0);
      check("t6b_count", int'(Byte_count), 0);
      check("t6b_cpu_run", int'(Cpu_run), 0);
      Reset = 1'b1;
      step();
    end
`endif

    repeat (3) step();
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
